// File: rtl/apb_rr_master_if.sv
// apb_rr_master_if: APB bus between the round-robin master and its slaves.
interface apb_rr_master_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_rr_master.sv
// apb_rr_master: shares one APB master port among NREQ requesters with round-robin
// arbitration, a wait-state timeout and registered completion status.
module apb_rr_master #(
  parameter int NREQ    = 4,
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      rdata,
  output logic               err,
  apb_rr_master_if.master    apb
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n, owner, owner_n, nxt_owner, base, off, win;
  logic [IW:0]     sum;
  logic [CW-1:0]   cnt, cnt_n;
  logic            psel, psel_n, penable, penable_n, pwrite, pwrite_n;
  logic            err_n, completing, found;
  logic [AW-1:0]   paddr, paddr_n;
  logic [DW-1:0]   pwdata, pwdata_n, rdata_n;
  logic [NREQ-1:0] done_n, own_hot, elig, rot;
  logic [AW-1:0]   addr_a [NREQ];
  logic [DW-1:0]   wdata_a [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign addr_a[i]  = req_addr[i*AW +: AW];
    assign wdata_a[i] = req_wdata[i*DW +: DW];
  end
  assign own_hot    = NREQ'(1) << owner;
  assign nxt_owner  = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
  assign completing = (state == ACCESS) && (apb.pready || cnt == CW'(TIMEOUT - 1));
  // The completing owner and any client still seeing its done pulse sit out this round.
  assign elig = req & ~done & ~(completing ? own_hot : '0);
  assign base = (state == ACCESS) ? nxt_owner : ptr;
  assign rot  = NREQ'({elig, elig} >> base);
  always_comb begin
    found = 1'b0;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) begin
        found = 1'b1;
        off = IW'(k);
      end
  end
  assign sum = {1'b0, base} + {1'b0, off};
  assign win = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    owner_n   = owner;
    cnt_n     = cnt;
    psel_n    = psel;
    penable_n = penable;
    pwrite_n  = pwrite;
    paddr_n   = paddr;
    pwdata_n  = pwdata;
    done_n    = '0;
    rdata_n   = rdata;
    err_n     = 1'b0;
    case (state)
      SETUP: begin
        state_n   = ACCESS;
        penable_n = 1'b1;
      end
      ACCESS:
        if (completing) begin
          done_n    = own_hot;
          err_n     = !apb.pready || apb.pslverr;
          rdata_n   = (apb.pready && !pwrite) ? apb.prdata : rdata;
          cnt_n     = '0;
          ptr_n     = nxt_owner;
          state_n   = IDLE;
          psel_n    = 1'b0;
          penable_n = 1'b0;
        end else
          cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    // A grant from IDLE or straight out of a completion goes to SETUP (back-to-back).
    if (found && (state == IDLE || completing)) begin
      state_n   = SETUP;
      psel_n    = 1'b1;
      penable_n = 1'b0;
      owner_n   = win;
      pwrite_n  = req_write[win];
      paddr_n   = addr_a[win];
      pwdata_n  = wdata_a[win];
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      done    <= '0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      cnt     <= cnt_n;
      psel    <= psel_n;
      penable <= penable_n;
      pwrite  <= pwrite_n;
      paddr   <= paddr_n;
      pwdata  <= pwdata_n;
      done    <= done_n;
      rdata   <= rdata_n;
      err     <= err_n;
    end
  assign apb.psel    = psel;
  assign apb.penable = penable;
  assign apb.pwrite  = pwrite;
  assign apb.paddr   = paddr;
  assign apb.pwdata  = pwdata;
endmodule
